// File: rtl/mmc_cmd_scheduler.sv
// Sector-request scheduler sharing the MMC SPI byte layer between the CMD17 read and CMD24 write engines.
// Optional watchdog abort path is compiled in when MMC_SCHED_TIMEOUT_EN is defined.
module mmc_cmd_scheduler #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iCONF_HC,
    input  logic        iREQ_VALID,
    output logic        oREQ_READY,
    input  logic        iREQ_WRITE,
    input  logic [31:0] iREQ_SECTOR,
    output logic        oDONE,
    output logic        oDONE_ERR,
    output logic        oRD_START,
    output logic        oWR_START,
    output logic [31:0] oENG_ADDR,
    input  logic        iRD_END,
    input  logic        iWR_END,
    output logic        oENG_RESET,
    input  logic        iRD_MMC_REQ,
    input  logic        iRD_MMC_CS,
    input  logic [7:0]  iRD_MMC_DATA,
    input  logic        iWR_MMC_REQ,
    input  logic        iWR_MMC_CS,
    input  logic [7:0]  iWR_MMC_DATA,
    output logic        oRD_MMC_BUSY,
    output logic        oWR_MMC_BUSY,
    output logic        oRD_MMC_VALID,
    output logic        oWR_MMC_VALID,
    output logic        oMMC_REQ,
    output logic        oMMC_CS,
    output logic [7:0]  oMMC_DATA,
    input  logic        iMMC_BUSY,
    input  logic        iMMC_VALID
);

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        RUN,
        ABORT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic        ownerEnd;
    logic        muxActive;

`ifdef MMC_SCHED_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= 32'h0;
`ifdef MMC_SCHED_TIMEOUT_EN
            cnt_q   <= 32'h0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
`ifdef MMC_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ownerEnd = owner_q ? iWR_END : iRD_END;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        oREQ_READY = 1'b0;
        oDONE      = 1'b0;
        oDONE_ERR  = 1'b0;
        oRD_START  = 1'b0;
        oWR_START  = 1'b0;
        oENG_RESET = 1'b0;
`ifdef MMC_SCHED_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                oREQ_READY = 1'b1;
                if (iREQ_VALID) begin
                    owner_d = iREQ_WRITE;
                    // Byte-addressed cards take sector*512; upper sector bits fall off.
                    addr_d  = iCONF_HC ? iREQ_SECTOR : {iREQ_SECTOR[22:0], 9'h0};
`ifdef MMC_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                oRD_START = ~owner_q;
                oWR_START = owner_q;
`ifdef MMC_SCHED_TIMEOUT_EN
                cnt_d     = 32'h0;
`endif
                state_d   = RUN;
            end
            RUN: begin
                if (ownerEnd) begin
                    state_d = DONE;
                end
`ifdef MMC_SCHED_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            ABORT: begin
`ifdef MMC_SCHED_TIMEOUT_EN
                oENG_RESET = 1'b1;
                err_d      = 1'b1;
`endif
                state_d    = DONE;
            end
            DONE: begin
                oDONE     = 1'b1;
`ifdef MMC_SCHED_TIMEOUT_EN
                oDONE_ERR = err_q;
`endif
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign oENG_ADDR = addr_q;
    assign muxActive = (state_q == DISPATCH) || (state_q == RUN);

    // Byte-layer mux is purely combinational so the owning engine sees no extra latency.
    always_comb begin
        oMMC_REQ      = 1'b0;
        oMMC_CS       = 1'b1;
        oMMC_DATA     = 8'hFF;
        oRD_MMC_BUSY  = 1'b1;
        oWR_MMC_BUSY  = 1'b1;
        oRD_MMC_VALID = 1'b0;
        oWR_MMC_VALID = 1'b0;
        if (muxActive) begin
            if (owner_q) begin
                oMMC_REQ      = iWR_MMC_REQ;
                oMMC_CS       = iWR_MMC_CS;
                oMMC_DATA     = iWR_MMC_DATA;
                oWR_MMC_BUSY  = iMMC_BUSY;
                oWR_MMC_VALID = iMMC_VALID;
            end else begin
                oMMC_REQ      = iRD_MMC_REQ;
                oMMC_CS       = iRD_MMC_CS;
                oMMC_DATA     = iRD_MMC_DATA;
                oRD_MMC_BUSY  = iMMC_BUSY;
                oRD_MMC_VALID = iMMC_VALID;
            end
        end
    end

endmodule

// File: tb/tb_mmc_cmd_scheduler.sv
// Self-checking bench for mmc_cmd_scheduler; expected completions are queued at request time and popped on oDONE.
module tb_mmc_cmd_scheduler;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC, iCONF_HC, iREQ_VALID, iREQ_WRITE;
    logic [31:0] iREQ_SECTOR;
    logic        oREQ_READY, oDONE, oDONE_ERR, oRD_START, oWR_START, oENG_RESET;
    logic [31:0] oENG_ADDR;
    logic        iRD_END, iWR_END;
    logic        iRD_MMC_REQ, iRD_MMC_CS, iWR_MMC_REQ, iWR_MMC_CS;
    logic [7:0]  iRD_MMC_DATA, iWR_MMC_DATA;
    logic        oRD_MMC_BUSY, oWR_MMC_BUSY, oRD_MMC_VALID, oWR_MMC_VALID;
    logic        oMMC_REQ, oMMC_CS;
    logic [7:0]  oMMC_DATA;
    logic        iMMC_BUSY, iMMC_VALID;

    typedef struct {
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    mmc_cmd_scheduler #(.TIMEOUT_CYCLES(32'd50)) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iCONF_HC(iCONF_HC),
        .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY), .iREQ_WRITE(iREQ_WRITE),
        .iREQ_SECTOR(iREQ_SECTOR), .oDONE(oDONE), .oDONE_ERR(oDONE_ERR),
        .oRD_START(oRD_START), .oWR_START(oWR_START), .oENG_ADDR(oENG_ADDR),
        .iRD_END(iRD_END), .iWR_END(iWR_END), .oENG_RESET(oENG_RESET),
        .iRD_MMC_REQ(iRD_MMC_REQ), .iRD_MMC_CS(iRD_MMC_CS), .iRD_MMC_DATA(iRD_MMC_DATA),
        .iWR_MMC_REQ(iWR_MMC_REQ), .iWR_MMC_CS(iWR_MMC_CS), .iWR_MMC_DATA(iWR_MMC_DATA),
        .oRD_MMC_BUSY(oRD_MMC_BUSY), .oWR_MMC_BUSY(oWR_MMC_BUSY),
        .oRD_MMC_VALID(oRD_MMC_VALID), .oWR_MMC_VALID(oWR_MMC_VALID),
        .oMMC_REQ(oMMC_REQ), .oMMC_CS(oMMC_CS), .oMMC_DATA(oMMC_DATA),
        .iMMC_BUSY(iMMC_BUSY), .iMMC_VALID(iMMC_VALID)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic test_reset();
        iRESET_SYNC = 1'b1; iCONF_HC = 1'b0; iREQ_VALID = 1'b0; iREQ_WRITE = 1'b0;
        iREQ_SECTOR = 32'h0; iRD_END = 1'b0; iWR_END = 1'b0;
        iRD_MMC_REQ = 1'b0; iRD_MMC_CS = 1'b1; iRD_MMC_DATA = 8'h00;
        iWR_MMC_REQ = 1'b0; iWR_MMC_CS = 1'b1; iWR_MMC_DATA = 8'h00;
        iMMC_BUSY = 1'b0; iMMC_VALID = 1'b0;
        tick(); tick();
        iRESET_SYNC = 1'b0;
        tick();
        vectors++;
        if ({oREQ_READY, oDONE, oDONE_ERR, oRD_START, oWR_START, oENG_RESET} !== 6'b100000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got %b want 100000",
                     {oREQ_READY, oDONE, oDONE_ERR, oRD_START, oWR_START, oENG_RESET});
        end
        vectors++;
        if ({oENG_ADDR, oMMC_REQ, oMMC_CS, oMMC_DATA} !== {32'h0, 1'b0, 1'b1, 8'hFF}) begin
            miscompares++;
            $display("[TB] FAIL reset_port got addr=%h req=%b cs=%b data=%h want 0/0/1/ff",
                     oENG_ADDR, oMMC_REQ, oMMC_CS, oMMC_DATA);
        end
        vectors++;
        if ({oRD_MMC_BUSY, oWR_MMC_BUSY, oRD_MMC_VALID, oWR_MMC_VALID} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL reset_busy got %b want 1100",
                     {oRD_MMC_BUSY, oWR_MMC_BUSY, oRD_MMC_VALID, oWR_MMC_VALID});
        end
    endtask

    // Checks oDONE is high this cycle and matches the oldest queued expectation.
    task automatic check_done(input string name);
        exp_t e;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL %s got done with empty scoreboard want queued entry", name);
        end else begin
            e = sbq.pop_front();
            if ({oDONE, oDONE_ERR, oENG_ADDR} !== {1'b1, e.err, e.addr}) begin
                miscompares++;
                $display("[TB] FAIL %s got done=%b err=%b addr=%h want 1/%b/%h",
                         name, oDONE, oDONE_ERR, oENG_ADDR, e.err, e.addr);
            end
        end
    endtask

    task automatic test_read();
        iCONF_HC = 1'b0; iREQ_WRITE = 1'b0; iREQ_SECTOR = 32'h3; iREQ_VALID = 1'b1;
        tick();
        iREQ_VALID = 1'b0;
        sbq.push_back('{err: 1'b0, addr: 32'h600});
        iRD_MMC_REQ = 1'b1; iRD_MMC_CS = 1'b0; iRD_MMC_DATA = 8'hA5; iMMC_VALID = 1'b1;
        #1;
        vectors++;
        if ({oRD_START, oWR_START, oENG_ADDR} !== {2'b10, 32'h600}) begin
            miscompares++;
            $display("[TB] FAIL rd_start got rd=%b wr=%b addr=%h want 1/0/00000600",
                     oRD_START, oWR_START, oENG_ADDR);
        end
        vectors++;
        if ({oMMC_REQ, oMMC_CS, oMMC_DATA, oRD_MMC_VALID, oWR_MMC_VALID, oWR_MMC_BUSY}
            !== {1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL rd_mux got req=%b cs=%b data=%h rv=%b wv=%b wb=%b want 1/0/a5/1/0/1",
                     oMMC_REQ, oMMC_CS, oMMC_DATA, oRD_MMC_VALID, oWR_MMC_VALID, oWR_MMC_BUSY);
        end
        iMMC_VALID = 1'b0;
        tick();
        vectors++;
        if (oRD_START !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_start_pulse got %b want 0", oRD_START);
        end
        for (int i = 0; i < 99; i++) begin
            iMMC_BUSY = i[0];
            #1;
            if (oRD_MMC_BUSY !== i[0] || oDONE !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL rd_run got busy=%b done=%b want %b/0", oRD_MMC_BUSY, oDONE, i[0]);
            end
            tick();
        end
        iMMC_BUSY = 1'b0;
        iRD_END = 1'b1;
        tick();
        iRD_END = 1'b0;
        iRD_MMC_REQ = 1'b0; iRD_MMC_CS = 1'b1;
        check_done("rd_done");
        tick();
        vectors++;
        if ({oREQ_READY, oDONE} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rd_idle got ready=%b done=%b want 1/0", oREQ_READY, oDONE);
        end
    endtask

    task automatic test_write();
        iCONF_HC = 1'b1; iREQ_WRITE = 1'b1; iREQ_SECTOR = 32'h12345678; iREQ_VALID = 1'b1;
        tick();
        sbq.push_back('{err: 1'b0, addr: 32'h12345678});
        vectors++;
        if ({oRD_START, oWR_START, oENG_ADDR} !== {2'b01, 32'h12345678}) begin
            miscompares++;
            $display("[TB] FAIL wr_start got rd=%b wr=%b addr=%h want 0/1/12345678",
                     oRD_START, oWR_START, oENG_ADDR);
        end
        tick();
        // iREQ_VALID stays high through RUN and must not be taken.
        for (int i = 0; i < 8; i++) begin
            iWR_MMC_DATA = 8'($urandom);
            iWR_MMC_CS   = i[0];
            iWR_MMC_REQ  = i[1];
            iRD_END      = (i == 3);
            #1;
            vectors++;
            if ({oMMC_DATA, oMMC_CS, oMMC_REQ, oRD_MMC_BUSY, oREQ_READY}
                !== {iWR_MMC_DATA, i[0], i[1], 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL wr_mux got data=%h cs=%b req=%b rb=%b ready=%b want %h/%b/%b/1/0",
                         oMMC_DATA, oMMC_CS, oMMC_REQ, oRD_MMC_BUSY, oREQ_READY, iWR_MMC_DATA, i[0], i[1]);
            end
            tick();
            vectors++;
            if (oDONE !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL wr_spurious got done=%b want 0", oDONE);
            end
        end
        iRD_END = 1'b0;
        iREQ_VALID = 1'b0;
        iWR_END = 1'b1;
        tick();
        iWR_END = 1'b0;
        check_done("wr_done");
        vectors++;
        if ({oMMC_CS, oMMC_DATA, oRD_MMC_BUSY, oWR_MMC_BUSY} !== {1'b1, 8'hFF, 2'b11}) begin
            miscompares++;
            $display("[TB] FAIL wr_done_mux got cs=%b data=%h busy=%b%b want 1/ff/11",
                     oMMC_CS, oMMC_DATA, oRD_MMC_BUSY, oWR_MMC_BUSY);
        end
        tick();
    endtask

`ifdef MMC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        iCONF_HC = 1'b1; iREQ_WRITE = 1'b0; iREQ_SECTOR = 32'h77; iREQ_VALID = 1'b1;
        tick();
        iREQ_VALID = 1'b0;
        sbq.push_back('{err: 1'b1, addr: 32'h77});
        tick();
        n = 0;
        while (oENG_RESET !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 50) begin
            miscompares++;
            $display("[TB] FAIL timeout_len got %0d run cycles want 50", n);
        end
        vectors++;
        if ({oMMC_CS, oDONE} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL abort_mux got cs=%b done=%b want 1/0", oMMC_CS, oDONE);
        end
        tick();
        check_done("timeout_done");
        tick();
        // END on the very cycle the watchdog expires must complete cleanly.
        iREQ_SECTOR = 32'h78; iREQ_VALID = 1'b1;
        tick();
        iREQ_VALID = 1'b0;
        sbq.push_back('{err: 1'b0, addr: 32'h78});
        tick();
        for (int i = 0; i < 49; i++) tick();
        iRD_END = 1'b1;
        #1;
        vectors++;
        if (oENG_RESET !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL race_reset got %b want 0", oENG_RESET);
        end
        tick();
        iRD_END = 1'b0;
        check_done("race_done");
        tick();
    endtask
`endif

    task automatic test_reset_mid_run();
        iCONF_HC = 1'b0; iREQ_WRITE = 1'b1; iREQ_SECTOR = 32'h10; iREQ_VALID = 1'b1;
        tick();
        iREQ_VALID = 1'b0;
        sbq.push_back('{err: 1'b0, addr: 32'h2000});
        iWR_MMC_CS = 1'b0; iWR_MMC_DATA = 8'h3C;
        tick(); tick();
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        sbq.delete();
        vectors++;
        if ({oREQ_READY, oMMC_CS, oMMC_DATA, oDONE, oENG_ADDR} !== {2'b11, 8'hFF, 1'b0, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL mid_reset got ready=%b cs=%b data=%h done=%b addr=%h want 1/1/ff/0/0",
                     oREQ_READY, oMMC_CS, oMMC_DATA, oDONE, oENG_ADDR);
        end
        for (int i = 0; i < 4; i++) begin
            iWR_END = (i == 0);
            tick();
            vectors++;
            if ({oDONE, oENG_RESET, oREQ_READY} !== 3'b001) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_quiet got done=%b eng_rst=%b ready=%b want 0/0/1",
                         oDONE, oENG_RESET, oREQ_READY);
            end
        end
        iWR_END = 1'b0;
        iWR_MMC_CS = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] sectors [3];
        int cyc;
        sectors[0] = 32'hFFFF_FFFF; sectors[1] = 32'h0080_0001; sectors[2] = 32'h5;
        iCONF_HC = 1'b0; iREQ_WRITE = 1'b0; iRD_END = 1'b1; iREQ_VALID = 1'b1;
        iREQ_SECTOR = sectors[0];
        for (int r = 0; r < 3; r++) begin
            cyc = 0;
            while (oREQ_READY !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
            end
            iREQ_SECTOR = sectors[r];
            tick();
            sbq.push_back('{err: 1'b0, addr: {sectors[r][22:0], 9'h0}});
            if (r == 2) iREQ_VALID = 1'b0;
            tick(); tick();
            check_done("b2b_done");
            tick();
            vectors++;
            if (oREQ_READY !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_turnaround got ready=%b want 1", oREQ_READY);
            end
        end
        iRD_END = 1'b0;
        tick();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_drain got %0d pending want 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
`ifdef MMC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
